// File: rtl/sysid_reader.sv
// sysid_reader: Avalon-MM read master that fetches the system ID (word 0)
// and build timestamp (word 1) from a sysid responder. It compares both
// words against compile-time expected values and reports pass/fail and
// read timeouts as status.
module sysid_reader #(
  parameter logic [31:0] EXPECTED_ID        = 32'h00000000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1483316685,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_q,
  output logic [31:0] timestamp_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A stalled read gives up on the edge where the counter would reach
  // TIMEOUT_CYCLES, so avm_read is seen high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] wait_cnt_q;
  logic [15:0] wait_cnt_d;
  logic [15:0] wait_cnt_inc;
  logic        avm_address_d;
  logic        avm_read_d;
  logic        busy_d;
  logic        done_d;
  logic        pass_d;
  logic        timeout_err_d;
  logic [31:0] id_d;
  logic [31:0] timestamp_d;

  // Saturating increment of the stall counter; it must never wrap to zero.
  always_comb begin
    wait_cnt_inc = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
  end

  // Next-state and next-output decode. Every output is computed here one
  // cycle ahead and registered below, so the ports never glitch.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    avm_address_d = avm_address;
    avm_read_d    = avm_read;
    busy_d        = busy;
    done_d        = 1'b0;
    pass_d        = pass;
    timeout_err_d = timeout_err;
    id_d          = id_q;
    timestamp_d   = timestamp_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = RD_ID;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b0;
          busy_d        = 1'b1;
          pass_d        = 1'b0;
          timeout_err_d = 1'b0;
          id_d          = 32'd0;
          timestamp_d   = 32'd0;
          wait_cnt_d    = 16'd0;
        end
      end

      RD_ID: begin
        if (!avm_waitrequest) begin
          id_d          = avm_readdata;
          wait_cnt_d    = 16'd0;
          avm_address_d = 1'b1;
          state_d       = RD_TS;
        end else if (wait_cnt_q >= TIMEOUT_LAST) begin
          wait_cnt_d    = wait_cnt_inc;
          avm_read_d    = 1'b0;
          avm_address_d = 1'b0;
          timeout_err_d = 1'b1;
          pass_d        = 1'b0;
          done_d        = 1'b1;
          state_d       = DONE;
        end else begin
          wait_cnt_d    = wait_cnt_inc;
        end
      end

      RD_TS: begin
        if (!avm_waitrequest) begin
          timestamp_d   = avm_readdata;
          avm_read_d    = 1'b0;
          avm_address_d = 1'b0;
          pass_d        = (id_q == EXPECTED_ID) &&
                          (avm_readdata == EXPECTED_TIMESTAMP) &&
                          !timeout_err;
          done_d        = 1'b1;
          state_d       = DONE;
        end else if (wait_cnt_q >= TIMEOUT_LAST) begin
          wait_cnt_d    = wait_cnt_inc;
          avm_read_d    = 1'b0;
          avm_address_d = 1'b0;
          timeout_err_d = 1'b1;
          pass_d        = 1'b0;
          done_d        = 1'b1;
          state_d       = DONE;
        end else begin
          wait_cnt_d    = wait_cnt_inc;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d       = IDLE;
        avm_read_d    = 1'b0;
        avm_address_d = 1'b0;
        busy_d        = 1'b0;
      end
    endcase
  end

  // State and output registers; reset is synchronous and beats start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 16'd0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      id_q        <= 32'd0;
      timestamp_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      avm_address <= avm_address_d;
      avm_read    <= avm_read_d;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      timeout_err <= timeout_err_d;
      id_q        <= id_d;
      timestamp_q <= timestamp_d;
    end
  end

endmodule

// File: tb/tb_sysid_reader.sv
// Directed testbench for sysid_reader with a small sysid slave model.
// Latencies are reported as the clock edge (counted from the edge that
// samples start) at which a signal is first sampled high.
module tb_sysid_reader;

  localparam logic [31:0] GOOD_TS = 32'd1483316685;

  logic        clock;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout_err;
  logic [31:0] id_q;
  logic [31:0] timestamp_q;

  int n_checks;
  int n_pass;

  // Slave model configuration and monitor statistics.
  logic [31:0] id_val;
  logic [31:0] ts_val;
  int          rem0;
  int          rem1;
  logic        stuck;
  int          reads0;
  int          reads1;
  int          first_addr;
  int          done_cnt;
  int          viol;
  logic        prev_stall;
  logic        prev_addr;

  sysid_reader #(
    .EXPECTED_ID       (32'h00000000),
    .EXPECTED_TIMESTAMP(GOOD_TS),
    .TIMEOUT_CYCLES    (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout_err    (timeout_err),
    .id_q           (id_q),
    .timestamp_q    (timestamp_q)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Monitor the bus mid-cycle, then drive the slave response for the next edge.
  always @(negedge clock) begin
    if (avm_read) begin
      if (reads0 + reads1 == 0) first_addr = int'(avm_address);
      if (avm_address) reads1++;
      else reads0++;
    end
    if (prev_stall && busy && !timeout_err &&
        (!avm_read || avm_address != prev_addr)) viol++;
    if (done) done_cnt++;

    if (avm_read) begin
      if (stuck || (!avm_address && rem0 > 0) || (avm_address && rem1 > 0)) begin
        avm_waitrequest = 1'b1;
        avm_readdata    = 32'hBAD0_0000;
        if (!stuck) begin
          if (avm_address) rem1--;
          else rem0--;
        end
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata    = avm_address ? ts_val : id_val;
      end
    end else begin
      avm_waitrequest = 1'b0;
      avm_readdata    = 32'hDEAD_BEEF;
    end
    prev_stall = avm_read && avm_waitrequest;
    prev_addr  = avm_address;
  end

  task automatic clear_stats();
    reads0     = 0;
    reads1     = 0;
    first_addr = -1;
    done_cnt   = 0;
    viol       = 0;
  endtask

  // Pulse start for one cycle; returns just after the edge that sampled it.
  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat is the edge at which done is sampled high,
  // or -1 if it never came. Returns one cycle after done was seen.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      if (done) begin
        lat = k + 1;
        break;
      end
      @(negedge clock);
      #1;
    end
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    n_checks++; if (avm_read !== 1'b0) $display("[TB] FAIL reset_read got=%b exp=0", avm_read); else n_pass++;
    n_checks++; if (avm_address !== 1'b0) $display("[TB] FAIL reset_addr got=%b exp=0", avm_address); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (pass !== 1'b0) $display("[TB] FAIL reset_pass got=%b exp=0", pass); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("[TB] FAIL reset_tmo got=%b exp=0", timeout_err); else n_pass++;
    n_checks++; if (id_q !== 32'd0) $display("[TB] FAIL reset_id got=%h exp=0", id_q); else n_pass++;
    n_checks++; if (timestamp_q !== 32'd0) $display("[TB] FAIL reset_ts got=%h exp=0", timestamp_q); else n_pass++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_pass();
    int lat;
    id_val = 32'd0; ts_val = GOOD_TS; rem0 = 0; rem1 = 0; stuck = 1'b0;
    clear_stats();
    pulse_start();
    n_checks++; if (busy !== 1'b1 || avm_read !== 1'b1 || avm_address !== 1'b0)
      $display("[TB] FAIL pass_first_cycle got busy=%b read=%b addr=%b exp 1 1 0", busy, avm_read, avm_address); else n_pass++;
    wait_done(lat);
    n_checks++; if (lat !== 3) $display("[TB] FAIL pass_latency got=%0d exp=3", lat); else n_pass++;
    n_checks++; if (pass !== 1'b1) $display("[TB] FAIL pass_flag got=%b exp=1", pass); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("[TB] FAIL pass_tmo got=%b exp=0", timeout_err); else n_pass++;
    n_checks++; if (id_q !== 32'd0) $display("[TB] FAIL pass_id got=%h exp=0", id_q); else n_pass++;
    n_checks++; if (timestamp_q !== GOOD_TS) $display("[TB] FAIL pass_ts got=%0d exp=%0d", timestamp_q, GOOD_TS); else n_pass++;
    n_checks++; if (reads0 !== 1 || reads1 !== 1 || first_addr !== 0)
      $display("[TB] FAIL pass_reads got r0=%0d r1=%0d first=%0d exp 1 1 0", reads0, reads1, first_addr); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("[TB] FAIL pass_done_count got=%0d exp=1", done_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL pass_busy_fall got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_mismatch();
    int lat;
    id_val = 32'd0; ts_val = 32'd1483316684; rem0 = 0; rem1 = 0; stuck = 1'b0;
    clear_stats();
    pulse_start();
    wait_done(lat);
    n_checks++; if (lat !== 3) $display("[TB] FAIL mismatch_latency got=%0d exp=3", lat); else n_pass++;
    n_checks++; if (pass !== 1'b0) $display("[TB] FAIL mismatch_pass got=%b exp=0", pass); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("[TB] FAIL mismatch_tmo got=%b exp=0", timeout_err); else n_pass++;
    n_checks++; if (timestamp_q !== 32'd1483316684) $display("[TB] FAIL mismatch_ts got=%0d exp=1483316684", timestamp_q); else n_pass++;
    n_checks++; if (id_q !== 32'd0) $display("[TB] FAIL mismatch_id got=%h exp=0", id_q); else n_pass++;
  endtask

  task automatic test_stall();
    int lat;
    id_val = 32'd0; ts_val = GOOD_TS; rem0 = 5; rem1 = 2; stuck = 1'b0;
    clear_stats();
    pulse_start();
    wait_done(lat);
    n_checks++; if (lat !== 10) $display("[TB] FAIL stall_latency got=%0d exp=10", lat); else n_pass++;
    n_checks++; if (viol !== 0) $display("[TB] FAIL stall_stability got=%0d exp=0", viol); else n_pass++;
    n_checks++; if (reads0 !== 6 || reads1 !== 3)
      $display("[TB] FAIL stall_reads got r0=%0d r1=%0d exp 6 3", reads0, reads1); else n_pass++;
    n_checks++; if (pass !== 1'b1 || timeout_err !== 1'b0)
      $display("[TB] FAIL stall_status got pass=%b tmo=%b exp 1 0", pass, timeout_err); else n_pass++;
    n_checks++; if (timestamp_q !== GOOD_TS) $display("[TB] FAIL stall_ts got=%0d exp=%0d", timestamp_q, GOOD_TS); else n_pass++;
  endtask

  task automatic test_timeout();
    int lat;
    id_val = 32'd0; ts_val = GOOD_TS; rem0 = 0; rem1 = 0; stuck = 1'b1;
    clear_stats();
    pulse_start();
    wait_done(lat);
    stuck = 1'b0;
    n_checks++; if (lat !== 9) $display("[TB] FAIL timeout_latency got=%0d exp=9", lat); else n_pass++;
    n_checks++; if (reads0 !== 8 || reads1 !== 0)
      $display("[TB] FAIL timeout_reads got r0=%0d r1=%0d exp 8 0", reads0, reads1); else n_pass++;
    n_checks++; if (timeout_err !== 1'b1) $display("[TB] FAIL timeout_flag got=%b exp=1", timeout_err); else n_pass++;
    n_checks++; if (pass !== 1'b0) $display("[TB] FAIL timeout_pass got=%b exp=0", pass); else n_pass++;
    n_checks++; if (timestamp_q !== 32'd0 || id_q !== 32'd0)
      $display("[TB] FAIL timeout_capture got id=%h ts=%h exp 0 0", id_q, timestamp_q); else n_pass++;
    n_checks++; if (viol !== 0) $display("[TB] FAIL timeout_stability got=%0d exp=0", viol); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    id_val = 32'h0000_1234; ts_val = GOOD_TS; rem0 = 0; rem1 = 20; stuck = 1'b0;
    clear_stats();
    pulse_start();
    repeat (3) begin
      @(negedge clock);
      #1;
    end
    n_checks++; if (avm_read !== 1'b1 || avm_address !== 1'b1 || id_q !== 32'h0000_1234)
      $display("[TB] FAIL rstmid_pre got read=%b addr=%b id=%h exp 1 1 00001234", avm_read, avm_address, id_q); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    #1;
    reset = 1'b0;
    n_checks++; if (avm_read !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL rstmid_ctrl got read=%b busy=%b done=%b exp 0 0 0", avm_read, busy, done); else n_pass++;
    n_checks++; if (id_q !== 32'd0 || timestamp_q !== 32'd0 || pass !== 1'b0 || timeout_err !== 1'b0)
      $display("[TB] FAIL rstmid_status got id=%h ts=%h pass=%b tmo=%b exp all 0", id_q, timestamp_q, pass, timeout_err); else n_pass++;
    repeat (12) @(negedge clock);
    #1;
    n_checks++; if (done_cnt !== 0) $display("[TB] FAIL rstmid_no_done got=%0d exp=0", done_cnt); else n_pass++;
    id_val = 32'd0; rem1 = 0;
    pulse_start();
    wait_done(lat);
    n_checks++; if (lat !== 3 || pass !== 1'b1)
      $display("[TB] FAIL rstmid_recheck got lat=%0d pass=%b exp 3 1", lat, pass); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    id_val = 32'd0; ts_val = GOOD_TS; rem0 = 0; rem1 = 0; stuck = 1'b0;
    clear_stats();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    #1;
    wait_done(lat);
    n_checks++; if (lat !== 3) $display("[TB] FAIL b2b_first_latency got=%0d exp=3", lat); else n_pass++;
    n_checks++; if (done_cnt !== 1 || reads0 + reads1 !== 2 || busy !== 1'b0)
      $display("[TB] FAIL b2b_single got dones=%0d reads=%0d busy=%b exp 1 2 0", done_cnt, reads0 + reads1, busy); else n_pass++;
    @(negedge clock);
    #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || avm_read !== 1'b1)
      $display("[TB] FAIL b2b_second_start got busy=%b read=%b exp 1 1", busy, avm_read); else n_pass++;
    wait_done(lat);
    n_checks++; if (lat !== 3 || pass !== 1'b1 || done_cnt !== 2 || reads0 + reads1 !== 4)
      $display("[TB] FAIL b2b_second got lat=%0d pass=%b dones=%0d reads=%0d exp 3 1 2 4",
               lat, pass, done_cnt, reads0 + reads1); else n_pass++;
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    n_checks = 0; n_pass = 0;
    reset = 1'b1; start = 1'b0;
    avm_waitrequest = 1'b0; avm_readdata = 32'd0;
    id_val = 32'd0; ts_val = GOOD_TS; rem0 = 0; rem1 = 0; stuck = 1'b0;
    prev_stall = 1'b0; prev_addr = 1'b0;
    clear_stats();
    test_reset();
    test_pass();
    test_mismatch();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sysid_reader.md
# sysid_reader

Avalon-MM read master (initiator) that interrogates a system-ID responder over its 1-bit-address control slave. On a start pulse it reads word 0 (system ID) and word 1 (build timestamp), holds both, and compares them against compile-time expected values. It sits between boot/monitor logic (or a Nios II-free power-on check) and the sysid slave. It reports pass/fail and read timeouts as status.

## Interface
- EXPECTED_ID, 32'h00000000, value word 0 must return
- EXPECTED_TIMESTAMP, 32'd1483316685, value word 1 must return
- TIMEOUT_CYCLES, 255, max cycles one read may be held off by waitrequest (1..65535)
- clock  in  1  single clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a check; ignored while busy
- avm_address  out  1  word select: 0 = ID, 1 = timestamp
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall; read completes in a cycle with avm_read=1 and waitrequest=0
- avm_readdata  in  32  sampled in the completing cycle (zero read latency)
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse at end of check
- pass  out  1  1 if both words matched and no timeout; valid from done, held until next accepted start
- timeout_err  out  1  1 if any read exceeded TIMEOUT_CYCLES; held like pass
- id_q  out  32  captured word 0
- timestamp_q  out  32  captured word 1

## Operation
- States: IDLE, RD_ID, RD_TS, DONE.
- IDLE: avm_read=0. start=1 -> RD_ID; clear pass, timeout_err, id_q, timestamp_q, wait counter.
- RD_ID: avm_read=1, avm_address=0. Completing cycle: id_q <= avm_readdata, counter cleared -> RD_TS.
- RD_TS: avm_read=1, avm_address=1. Completing cycle: timestamp_q <= avm_readdata -> DONE.
- DONE: avm_read=0, done=1 for exactly this cycle; pass <= (id_q==EXPECTED_ID) && (timestamp_q==EXPECTED_TIMESTAMP) && !timeout_err -> IDLE.
- Wait counter: 16-bit, increments each cycle avm_read=1 and avm_waitrequest=1. When counter reaches TIMEOUT_CYCLES while still stalled: drop avm_read, set timeout_err=1, capture nothing further, -> DONE (pass=0). Counter saturates, never wraps.
- avm_address and avm_read held stable while waitrequest=1 (Avalon rule); no change of address mid-transfer.
- start during busy/DONE: ignored, no queuing.
- Comparison is full 32-bit equality; no masking.

## Timing
- Reset (sync, active-high, dominant over start): state=IDLE, avm_read=0, avm_address=0, busy=0, done=0, pass=0, timeout_err=0, id_q=0, timestamp_q=0, counter=0.
- Reset mid-transfer: next edge forces all of the above; avm_read deasserts the cycle after reset is sampled; captured words discarded.
- All outputs registered.
- start sampled at edge N -> avm_read=1, address 0, busy=1 from N+1.
- With waitrequest=0 throughout: word 0 completes at N+1, word 1 at N+2, done pulse and pass valid at N+3, busy falls at N+4. Total start-to-done 3 cycles.
- Each stalled cycle adds one cycle to that read.
- Timeout: read with continuous waitrequest=1 asserts avm_read for exactly TIMEOUT_CYCLES cycles, then DONE next cycle.
- done and start in the same cycle: start ignored (state is DONE). start in the cycle after done (IDLE) accepted.

## Test plan
- Slave model returns 0 / 1483316685 with waitrequest=0; pulse start -> done at start+3, pass=1, timeout_err=0, id_q=0, timestamp_q=1483316685, exactly two read cycles with address 0 then 1.
- Slave returns timestamp 1483316684 -> pass=0, timeout_err=0, timestamp_q=1483316684; id_q=0.
- waitrequest=1 for 5 cycles on word 0 and 2 on word 1 -> address/read stable during stalls, done at start+10, pass=1.
- waitrequest stuck high, TIMEOUT_CYCLES=8 -> avm_read high exactly 8 cycles at address 0, then done, timeout_err=1, pass=0, timestamp_q=0.
- Assert reset during RD_TS stall -> next cycle avm_read=0, busy=0, all status/capture zero, no done pulse; new start afterwards runs a clean check to pass=1.
- start pulses repeated every cycle for 10 cycles -> only one check executes (two reads, one done); start in cycle after done begins a second check.
